stack_op_sequencer: RTL

Sequences all stack traffic for the pipelined core. It accepts single-word and multi-word stack operations from the execute stage and the interrupt unit, arbitrates between them, and drives the stack pointer strobes (ISP/DSP/LSP) together with the matching data-memory read/write strobes. It also tracks stack depth and flags overflow or underflow. It sits between the control-code generator and the stack pointer module and data-memory port.

---
 rtl/stack_op_sequencer.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/stack_op_sequencer.sv
// Stack operation sequencer: arbitrates execute-stage and interrupt stack ops,
// drives the stack pointer strobes (ISP/DSP/LSP) and the data-memory strobes.
// Build option: define SP_BOUNDS_CHECK_EN for depth tracking, the Fault
// register, the FAULT_HOLD state and overflow/underflow strobe suppression.
// Without it pushes and pops always strobe and Fault reads as zero.
module stack_op_sequencer #(
  parameter logic [15:0] DEPTH_MAX = 16'd256,
  parameter int unsigned DW        = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ExReq,
  input  logic [2:0]    ExOp,
  input  logic [DW-1:0] ExData,
  output logic          ExAck,
  input  logic          IntReq,
  output logic          IntAck,
  input  logic [DW-1:0] PCIn,
  input  logic [DW-1:0] FlagsIn,
  output logic          ISP,
  output logic          DSP,
  output logic          LSP,
  output logic [DW-1:0] SPLoadVal,
  output logic          MemWr,
  output logic          MemRd,
  output logic [DW-1:0] WrData,
  output logic [1:0]    PopDest,
  output logic          Busy,
  output logic          Done,
  output logic [1:0]    Fault,
  input  logic          FaultClr
);

  localparam int unsigned DEPTH_W = 16;

  localparam logic [2:0] OP_PUSH   = 3'd1;
  localparam logic [2:0] OP_POP    = 3'd2;
  localparam logic [2:0] OP_CALL   = 3'd3;
  localparam logic [2:0] OP_RET    = 3'd4;
  localparam logic [2:0] OP_LOADSP = 3'd5;
  localparam logic [2:0] OP_RETI   = 3'd7;

  localparam logic [1:0] DEST_REG   = 2'd0;
  localparam logic [1:0] DEST_PC    = 2'd1;
  localparam logic [1:0] DEST_FLAGS = 2'd2;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    S1         = 2'd1,
    S2         = 2'd2,
    FAULT_HOLD = 2'd3
  } state_e;

  // Which multi-word op is in flight while in S1.
  typedef enum logic {
    KIND_INT  = 1'b0,
    KIND_RETI = 1'b1
  } kind_e;

  state_e        state_q, state_d;
  kind_e         kind_q, kind_d;
  logic [DW-1:0] flags_q, flags_d;

  logic          ex_ack, int_ack, done;
  logic          push_try, pop_try, load_try;
  logic [DW-1:0] push_val;
  logic [1:0]    pop_dest;
  logic          ovf, unf;
  logic          wr_c, rd_c, ld_c;

`ifdef SP_BOUNDS_CHECK_EN
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [1:0]         fault_q, fault_d;
`endif

  // State, op-kind and latched flags registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      kind_q  <= KIND_INT;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      flags_q <= flags_d;
    end
  end

  // Arbitration, per-cycle word intent, bounds check and next state.
  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    flags_d  = flags_q;
    ex_ack   = 1'b0;
    int_ack  = 1'b0;
    done     = 1'b0;
    push_try = 1'b0;
    pop_try  = 1'b0;
    load_try = 1'b0;
    push_val = '0;
    pop_dest = DEST_REG;
    ovf      = 1'b0;
    unf      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (IntReq) begin
          int_ack  = 1'b1;
          push_try = 1'b1;
          push_val = PCIn;
          flags_d  = FlagsIn;
          kind_d   = KIND_INT;
          state_d  = S1;
        end else if (ExReq) begin
          ex_ack = 1'b1;
          done   = 1'b1;
          case (ExOp)
            OP_PUSH: begin
              push_try = 1'b1;
              push_val = ExData;
            end
            OP_CALL: begin
              push_try = 1'b1;
              push_val = PCIn;
            end
            OP_POP: begin
              pop_try  = 1'b1;
              pop_dest = DEST_REG;
            end
            OP_RET: begin
              pop_try  = 1'b1;
              pop_dest = DEST_PC;
            end
            OP_LOADSP: begin
              load_try = 1'b1;
            end
            OP_RETI: begin
              pop_try  = 1'b1;
              pop_dest = DEST_FLAGS;
              done     = 1'b0;
              kind_d   = KIND_RETI;
              state_d  = S1;
            end
            default: begin
            end
          endcase
        end
      end
      S1: begin
        done    = 1'b1;
        state_d = IDLE;
        if (kind_q == KIND_INT) begin
          push_try = 1'b1;
          push_val = flags_q;
        end else begin
          pop_try  = 1'b1;
          pop_dest = DEST_PC;
        end
      end
      FAULT_HOLD: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
`ifdef SP_BOUNDS_CHECK_EN
    ovf = push_try && (depth_q == DEPTH_MAX);
    unf = pop_try && (depth_q == '0);
    if (ovf || unf) begin
      done    = 1'b1;
      state_d = FAULT_HOLD;
    end
`endif
  end

`ifdef SP_BOUNDS_CHECK_EN
  // Depth tracking and sticky fault update; a new fault beats FaultClr.
  always_comb begin
    depth_d = depth_q;
    if (load_try) begin
      depth_d = '0;
    end else if (push_try && !ovf) begin
      depth_d = depth_q + DEPTH_W'(1);
    end else if (pop_try && !unf) begin
      depth_d = depth_q - DEPTH_W'(1);
    end
    fault_d = (FaultClr ? 2'b00 : fault_q) | {unf, ovf};
  end

  // Depth and fault registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q <= '0;
      fault_q <= 2'b00;
    end else begin
      depth_q <= depth_d;
      fault_q <= fault_d;
    end
  end

  assign Fault = fault_q;
`else
  logic        unused_fault_clr;
  logic [15:0] unused_depth_max;
  assign unused_fault_clr = FaultClr;
  assign unused_depth_max = DEPTH_MAX;
  assign Fault            = 2'b00;
`endif

  // Strobes fire in the cycle they are decided; reset silences them at once.
  assign wr_c = rst_n & push_try & ~ovf;
  assign rd_c = rst_n & pop_try & ~unf;
  assign ld_c = rst_n & load_try;

  assign ExAck     = rst_n & ex_ack;
  assign IntAck    = rst_n & int_ack;
  assign DSP       = wr_c;
  assign MemWr     = wr_c;
  assign WrData    = wr_c ? push_val : '0;
  assign ISP       = rd_c;
  assign MemRd     = rd_c;
  assign PopDest   = rd_c ? pop_dest : DEST_REG;
  assign LSP       = ld_c;
  assign SPLoadVal = ld_c ? ExData : '0;
  assign Busy      = rst_n & (state_q != IDLE);
  assign Done      = rst_n & done;

endmodule
